bsg_manycore_dpi_tile_chan_mux: RTL and testbench

BSG_MANYCORE_DPI_TILE_CHAN_MUX -- requirements
Module: bsg_manycore_dpi_tile_chan_mux

---
 rtl/bsg_manycore_dpi_tile_chan_mux.sv | 173 +++++++++++++++++
 tb/tb_bsg_manycore_dpi_tile_chan_mux.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_dpi_tile_chan_mux.sv
// rtl/bsg_manycore_dpi_tile_chan_mux.sv - multi-channel request mux with credit-tracked response routing
//
// Purpose: merges num_chan_p buffered request channels onto one endpoint stream
// through a locking round-robin arbiter. It tracks the outstanding requests of
// each channel and routes tagged responses back to the channel that issued them.
//
// Ports:
//   clk_i, reset_n_i        - clock; asynchronous active-low reset
//   chan_req_v_i/data_i     - per-channel request words (channel c in slice c)
//   chan_req_ready_o        - per-channel buffer not full
//   endpoint_req_*          - merged outbound request stream
//   mc_rsp_*                - inbound responses; channel id sits at tag_lsb_p
//   chan_rsp_v_o/data_o     - registered one-hot response valid and shared data
//   chan_credits_o          - per-channel outstanding-request counts, packed
//   err_o                   - sticky flag for responses that cannot be routed
module bsg_manycore_dpi_tile_chan_mux #(
    parameter int fifo_width_p   = 128,
    parameter int num_chan_p     = 4,
    parameter int req_fifo_els_p = 4,
    parameter int chan_credits_p = 8,
    parameter int tag_lsb_p      = 0,
    localparam int idw_lp        = $clog2(num_chan_p),
    localparam int cw_lp         = $clog2(chan_credits_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_chan_p-1:0]            chan_req_v_i,
    input  logic [num_chan_p*fifo_width_p-1:0] chan_req_data_i,
    output logic [num_chan_p-1:0]            chan_req_ready_o,
    output logic                             endpoint_req_v_o,
    output logic [fifo_width_p-1:0]          endpoint_req_data_o,
    input  logic                             endpoint_req_ready_i,
    input  logic                             mc_rsp_v_i,
    input  logic [fifo_width_p-1:0]          mc_rsp_data_i,
    output logic                             mc_rsp_ready_o,
    output logic [num_chan_p-1:0]            chan_rsp_v_o,
    output logic [fifo_width_p-1:0]          chan_rsp_data_o,
    output logic [num_chan_p*cw_lp-1:0]      chan_credits_o,
    output logic                             err_o
);
    localparam int pw_lp   = $clog2(req_fifo_els_p);
    localparam int cntw_lp = $clog2(req_fifo_els_p + 1);

    logic [fifo_width_p-1:0] mem [num_chan_p][req_fifo_els_p];
    logic [pw_lp-1:0]        wptr   [num_chan_p];
    logic [pw_lp-1:0]        rptr   [num_chan_p];
    logic [cntw_lp-1:0]      count  [num_chan_p];
    logic [cw_lp-1:0]        credit [num_chan_p];

    logic                    ready_en;
    logic [num_chan_p-1:0]   full, eligible, push, pop, rsp_hit;
    logic [idw_lp-1:0]       rr, lock_chan, grant, rsp_id;
    logic                    locked, found, handshake, rsp_ok;

    // ready_en keeps every channel closed during reset and opens them on the
    // first clock edge after release.
    assign chan_req_ready_o = {num_chan_p{ready_en}} & ~full;
    assign mc_rsp_ready_o   = 1'b1;

    always_comb begin
        full     = '0;
        eligible = '0;
        push     = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            full[c]     = (count[c] == cntw_lp'(req_fifo_els_p));
            eligible[c] = (count[c] != '0) && (credit[c] < cw_lp'(chan_credits_p));
            push[c]     = chan_req_v_i[c] && chan_req_ready_o[c];
        end
    end

    // A locked grant overrides arbitration so channel and head word stay put
    // until the endpoint accepts; otherwise search upward from rr with wrap.
    always_comb begin
        found = 1'b0;
        grant = lock_chan;
        if (!locked) begin
            for (int i = 0; i < num_chan_p; i++) begin
                if (!found && eligible[(int'(rr) + i) % num_chan_p]) begin
                    found = 1'b1;
                    grant = idw_lp'((int'(rr) + i) % num_chan_p);
                end
            end
        end
    end

    assign endpoint_req_v_o    = locked || found;
    assign endpoint_req_data_o = mem[grant][rptr[grant]];
    assign handshake           = endpoint_req_v_o && endpoint_req_ready_i;
    assign pop                 = handshake ? (num_chan_p'(1) << grant) : '0;

    // Out-of-range ids match no channel and so fall into the error path.
    assign rsp_id = mc_rsp_data_i[tag_lsb_p +: idw_lp];
    always_comb begin
        rsp_hit = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            rsp_hit[c] = mc_rsp_v_i && (rsp_id == idw_lp'(c)) && (credit[c] != '0);
        end
    end
    assign rsp_ok = |rsp_hit;

    always_comb begin
        chan_credits_o = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            chan_credits_o[c*cw_lp +: cw_lp] = credit[c];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < num_chan_p; c++) begin
            if (push[c]) begin
                mem[c][wptr[c]] <= chan_req_data_i[c*fifo_width_p +: fifo_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en        <= 1'b0;
            rr              <= '0;
            locked          <= 1'b0;
            lock_chan       <= '0;
            err_o           <= 1'b0;
            chan_rsp_v_o    <= '0;
            chan_rsp_data_o <= '0;
            for (int c = 0; c < num_chan_p; c++) begin
                wptr[c]   <= '0;
                rptr[c]   <= '0;
                count[c]  <= '0;
                credit[c] <= '0;
            end
        end else begin
            ready_en <= 1'b1;

            // Full status is registered, so a pop frees its slot for the
            // producer only from the following cycle.
            for (int c = 0; c < num_chan_p; c++) begin
                if (push[c]) begin
                    wptr[c] <= (wptr[c] == pw_lp'(req_fifo_els_p - 1)) ? '0 : wptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rptr[c] <= (rptr[c] == pw_lp'(req_fifo_els_p - 1)) ? '0 : rptr[c] + 1'b1;
                end
                if (push[c] && !pop[c]) begin
                    count[c] <= count[c] + 1'b1;
                end else if (pop[c] && !push[c]) begin
                    count[c] <= count[c] - 1'b1;
                end
                // Simultaneous issue and response cancel out.
                if (pop[c] && !rsp_hit[c]) begin
                    credit[c] <= credit[c] + 1'b1;
                end else if (rsp_hit[c] && !pop[c]) begin
                    credit[c] <= credit[c] - 1'b1;
                end
            end

            if (handshake) begin
                locked <= 1'b0;
                rr     <= (grant == idw_lp'(num_chan_p - 1)) ? '0 : grant + 1'b1;
            end else if (endpoint_req_v_o) begin
                locked    <= 1'b1;
                lock_chan <= grant;
            end

            chan_rsp_v_o <= rsp_hit;
            if (rsp_ok) begin
                chan_rsp_data_o <= mc_rsp_data_i;
            end
            if (mc_rsp_v_i && !rsp_ok) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bsg_manycore_dpi_tile_chan_mux.sv
// tb/tb_bsg_manycore_dpi_tile_chan_mux.sv - directed self-checking bench for the channel mux
module tb_bsg_manycore_dpi_tile_chan_mux;
    localparam int W  = 128;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   req_v;
    logic [NC*W-1:0] req_data;
    logic [NC-1:0]   req_ready;
    logic            ep_v;
    logic [W-1:0]    ep_data;
    logic            ep_ready;
    logic            rsp_v;
    logic [W-1:0]    rsp_data;
    logic            rsp_ready;
    logic [NC-1:0]   crsp_v;
    logic [W-1:0]    crsp_data;
    logic [7:0]      credits;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_w;

    bsg_manycore_dpi_tile_chan_mux #(
        .fifo_width_p(W), .num_chan_p(NC), .req_fifo_els_p(2),
        .chan_credits_p(2), .tag_lsb_p(0)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .chan_req_v_i(req_v), .chan_req_data_i(req_data), .chan_req_ready_o(req_ready),
        .endpoint_req_v_o(ep_v), .endpoint_req_data_o(ep_data), .endpoint_req_ready_i(ep_ready),
        .mc_rsp_v_i(rsp_v), .mc_rsp_data_i(rsp_data), .mc_rsp_ready_o(rsp_ready),
        .chan_rsp_v_o(crsp_v), .chan_rsp_data_o(crsp_data),
        .chan_credits_o(credits), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [W-1:0] d);
        req_data[c*W +: W] = d;
    endtask

    function automatic logic [W-1:0] rsp_word(input int id, input logic [7:0] salt);
        rsp_word = {88'h0, salt, 30'h0, id[1:0]};
    endfunction

    task automatic send_rsp(input int id, input logic [7:0] salt);
        rsp_v = 1'b1;
        rsp_data = rsp_word(id, salt);
        step();
        rsp_v = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_ready: got %h want 0", req_ready); end
        n_checks++; if (ep_v !== 1'b0) begin n_fail++; $display("FAIL rst_ep_v: got %b want 0", ep_v); end
        n_checks++; if (credits !== 8'h00) begin n_fail++; $display("FAIL rst_credits: got %h want 00", credits); end
        n_checks++; if ({err, crsp_v} !== 5'h0) begin n_fail++; $display("FAIL rst_err_rsp: got %h want 0", {err, crsp_v}); end
        n_checks++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL rsp_ready: got %b want 1", rsp_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rel_ready_early: got %h want 0", req_ready); end
        step();
        n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL rel_ready: got %h want F", req_ready); end
    endtask

    task automatic test_issue_order;
        ep_ready = 1'b1;
        req_v = 4'hF;
        for (int c = 0; c < NC; c++) set_req(c, W'(8'hA0 + c));
        step();
        req_v = 4'h0;
        for (int c = 0; c < NC; c++) begin
            n_checks++; if (ep_v !== 1'b1 || ep_data !== W'(8'hA0 + c))
                begin n_fail++; $display("FAIL order_%0d: got v=%b d=%h want v=1 d=%h", c, ep_v, ep_data, 8'hA0 + c); end
            step();
        end
        n_checks++; if (ep_v !== 1'b0) begin n_fail++; $display("FAIL order_idle: got %b want 0", ep_v); end
        n_checks++; if (credits !== 8'h55) begin n_fail++; $display("FAIL order_credits: got %h want 55", credits); end
        for (int c = 0; c < NC; c++) begin
            send_rsp(c, 8'h10 + 8'(c));
            n_checks++; if (crsp_v !== (4'b1 << c) || crsp_data !== rsp_word(c, 8'h10 + 8'(c)))
                begin n_fail++; $display("FAIL route_%0d: got v=%b d=%h want v=%b", c, crsp_v, crsp_data, 4'b1 << c); end
        end
        step();
        n_checks++; if (crsp_v !== 4'h0 || credits !== 8'h00)
            begin n_fail++; $display("FAIL route_done: got v=%b cr=%h want 0/00", crsp_v, credits); end
    endtask

    task automatic test_credit_limit;
        req_v = 4'b0100;
        set_req(2, W'(8'hB0));
        n_checks++; if (req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL cl_ready: got %b want 1", req_ready[2]); end
        step();
        set_req(2, W'(8'hB1));
        n_checks++; if (ep_data !== W'(8'hB0)) begin n_fail++; $display("FAIL cl_b0: got %h want b0", ep_data); end
        step();
        set_req(2, W'(8'hB2));
        n_checks++; if (ep_data !== W'(8'hB1)) begin n_fail++; $display("FAIL cl_b1: got %h want b1", ep_data); end
        step();
        req_v = 4'h0;
        n_checks++; if (ep_v !== 1'b0 || credits[5:4] !== 2'd2)
            begin n_fail++; $display("FAIL cl_block: got v=%b cr=%0d want 0/2", ep_v, credits[5:4]); end
        step();
        n_checks++; if (ep_v !== 1'b0) begin n_fail++; $display("FAIL cl_block2: got %b want 0", ep_v); end
        send_rsp(2, 8'h20);
        n_checks++; if (credits[5:4] !== 2'd1 || ep_v !== 1'b1 || ep_data !== W'(8'hB2) || crsp_v !== 4'b0100)
            begin n_fail++; $display("FAIL cl_resume: got cr=%0d v=%b d=%h rv=%b want 1/1/b2/0100", credits[5:4], ep_v, ep_data, crsp_v); end
        step();
        n_checks++; if (ep_v !== 1'b0 || credits[5:4] !== 2'd2)
            begin n_fail++; $display("FAIL cl_after: got v=%b cr=%0d want 0/2", ep_v, credits[5:4]); end
        send_rsp(2, 8'h21);
        send_rsp(2, 8'h22);
        step();
        n_checks++; if (credits !== 8'h00) begin n_fail++; $display("FAIL cl_drain: got %h want 00", credits); end
    endtask

    task automatic test_lock;
        ep_ready = 1'b0;
        req_v = 4'b0010;
        set_req(1, W'(8'hC1));
        step();
        req_v = 4'b0001;
        set_req(0, W'(8'hD0));
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (ep_v !== 1'b1 || ep_data !== W'(8'hC1))
                begin n_fail++; $display("FAIL lock_hold_%0d: got v=%b d=%h want 1/c1", k, ep_v, ep_data); end
            step();
            if (k == 0) set_req(0, W'(8'hD1));
            if (k == 1) req_v = 4'h0;
        end
        n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL lock_full0: got %b want 0", req_ready[0]); end
        ep_ready = 1'b1;
        #1;
        n_checks++; if (ep_data !== W'(8'hC1)) begin n_fail++; $display("FAIL lock_rel: got %h want c1", ep_data); end
        step();
        n_checks++; if (ep_v !== 1'b1 || ep_data !== W'(8'hD0))
            begin n_fail++; $display("FAIL lock_wrap: got v=%b d=%h want 1/d0", ep_v, ep_data); end
        step();
        n_checks++; if (ep_data !== W'(8'hD1)) begin n_fail++; $display("FAIL lock_d1: got %h want d1", ep_data); end
        step();
        n_checks++; if (ep_v !== 1'b0 || credits !== 8'h06)
            begin n_fail++; $display("FAIL lock_credits: got v=%b cr=%h want 0/06", ep_v, credits); end
        send_rsp(0, 8'h30);
        send_rsp(0, 8'h31);
        send_rsp(1, 8'h32);
        step();
        n_checks++; if (credits !== 8'h00) begin n_fail++; $display("FAIL lock_drain: got %h want 00", credits); end
    endtask

    task automatic test_errors;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", err); end
        send_rsp(3, 8'h40);
        n_checks++; if (crsp_v !== 4'h0 || err !== 1'b1 || credits !== 8'h00)
            begin n_fail++; $display("FAIL err_drop: got rv=%b err=%b cr=%h want 0/1/00", crsp_v, err, credits); end
        repeat (3) step();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        req_v = 4'b0010;
        set_req(1, W'(8'hE1));
        step();
        req_v = 4'h0;
        step();
        n_checks++; if (credits !== 8'h04) begin n_fail++; $display("FAIL err_issue: got %h want 04", credits); end
        send_rsp(1, 8'h41);
        exp_w = rsp_word(1, 8'h41);
        n_checks++; if (crsp_v !== 4'b0010 || crsp_data !== exp_w || credits !== 8'h00 || err !== 1'b1)
            begin n_fail++; $display("FAIL err_route: got rv=%b d=%h cr=%h err=%b", crsp_v, crsp_data, credits, err); end
        step();
        n_checks++; if (crsp_v !== 4'h0 || crsp_data !== exp_w)
            begin n_fail++; $display("FAIL rsp_hold: got rv=%b d=%h want 0/%h", crsp_v, crsp_data, exp_w); end
    endtask

    task automatic test_same_cycle;
        req_v = 4'b0001;
        set_req(0, W'(8'hF0));
        step();
        set_req(0, W'(8'hF1));
        n_checks++; if (ep_data !== W'(8'hF0)) begin n_fail++; $display("FAIL sc_f0: got %h want f0", ep_data); end
        step();
        req_v = 4'h0;
        rsp_v = 1'b1;
        rsp_data = rsp_word(0, 8'h50);
        n_checks++; if (credits[1:0] !== 2'd1 || ep_data !== W'(8'hF1))
            begin n_fail++; $display("FAIL sc_pre: got cr=%0d d=%h want 1/f1", credits[1:0], ep_data); end
        step();
        rsp_v = 1'b0;
        n_checks++; if (credits[1:0] !== 2'd1 || crsp_v !== 4'b0001)
            begin n_fail++; $display("FAIL sc_cancel: got cr=%0d rv=%b want 1/0001", credits[1:0], crsp_v); end
        send_rsp(0, 8'h51);
        n_checks++; if (credits !== 8'h00) begin n_fail++; $display("FAIL sc_drain: got %h want 00", credits); end

        ep_ready = 1'b0;
        req_v = 4'b0001;
        set_req(0, W'(8'h60));
        step();
        set_req(0, W'(8'h61));
        step();
        n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ff_full: got %b want 0", req_ready[0]); end
        set_req(0, W'(8'h62));
        ep_ready = 1'b1;
        #1;
        n_checks++; if (ep_data !== W'(8'h60)) begin n_fail++; $display("FAIL ff_head: got %h want 60", ep_data); end
        step();
        ep_ready = 1'b0;
        n_checks++; if (req_ready[0] !== 1'b1 || ep_data !== W'(8'h61))
            begin n_fail++; $display("FAIL ff_freed: got rdy=%b d=%h want 1/61", req_ready[0], ep_data); end
        step();
        req_v = 4'h0;
        n_checks++; if (req_ready[0] !== 1'b0 || ep_data !== W'(8'h61))
            begin n_fail++; $display("FAIL ff_refull: got rdy=%b d=%h want 0/61", req_ready[0], ep_data); end
        ep_ready = 1'b1;
        step();
        n_checks++; if (ep_v !== 1'b0 || credits[1:0] !== 2'd2)
            begin n_fail++; $display("FAIL ff_block: got v=%b cr=%0d want 0/2", ep_v, credits[1:0]); end
        ep_ready = 1'b0;
        send_rsp(0, 8'h52);
        n_checks++; if (ep_v !== 1'b1 || ep_data !== W'(8'h62))
            begin n_fail++; $display("FAIL ff_nolost: got v=%b d=%h want 1/62", ep_v, ep_data); end
    endtask

    task automatic test_async_reset;
        step();
        n_checks++; if (ep_v !== 1'b1 || credits !== 8'h01 || err !== 1'b1)
            begin n_fail++; $display("FAIL ar_pre: got v=%b cr=%h err=%b want 1/01/1", ep_v, credits, err); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ep_v !== 1'b0 || req_ready !== 4'h0 || credits !== 8'h00 || err !== 1'b0 || crsp_v !== 4'h0 || crsp_data !== '0)
            begin n_fail++; $display("FAIL ar_async: got v=%b rdy=%h cr=%h err=%b rv=%b d=%h", ep_v, req_ready, credits, err, crsp_v, crsp_data); end
        step();
        n_checks++; if (ep_v !== 1'b0 || req_ready !== 4'h0)
            begin n_fail++; $display("FAIL ar_held: got v=%b rdy=%h want 0/0", ep_v, req_ready); end
        rst_n = 1'b1;
        step();
        n_checks++; if (req_ready !== 4'hF || credits !== 8'h00 || err !== 1'b0)
            begin n_fail++; $display("FAIL ar_release: got rdy=%h cr=%h err=%b want F/00/0", req_ready, credits, err); end
        ep_ready = 1'b1;
        req_v = 4'b1001;
        set_req(0, W'(8'h70));
        set_req(3, W'(8'h73));
        step();
        req_v = 4'h0;
        n_checks++; if (ep_v !== 1'b1 || ep_data !== W'(8'h70))
            begin n_fail++; $display("FAIL ar_first: got v=%b d=%h want 1/70", ep_v, ep_data); end
        step();
        n_checks++; if (ep_data !== W'(8'h73)) begin n_fail++; $display("FAIL ar_second: got %h want 73", ep_data); end
    endtask

    initial begin
        rst_n    = 1'b0;
        req_v    = '0;
        req_data = '0;
        ep_ready = 1'b0;
        rsp_v    = 1'b0;
        rsp_data = '0;
        test_reset();
        test_issue_order();
        test_credit_limit();
        test_lock();
        test_errors();
        test_same_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
